// File: rtl/cu_pkg.sv
// Shared definitions for the pipelined RV32I control unit.
//   Opcode constants, RAM-op and ALU-op encodings, PC-select codes,
//   the ID/EX control word (ctrl_t) and the RUN/KILL state type.
package cu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] RAM_LB  = 3'b000;
  localparam logic [2:0] RAM_LH  = 3'b001;
  localparam logic [2:0] RAM_LW  = 3'b010;
  localparam logic [2:0] RAM_LBU = 3'b011;
  localparam logic [2:0] RAM_LHU = 3'b100;
  localparam logic [2:0] RAM_SB  = 3'b101;
  localparam logic [2:0] RAM_SH  = 3'b110;
  localparam logic [2:0] RAM_SW  = 3'b111;

  // aluop[4] = M op, aluop[3] = alternate (sub/sra), aluop[2:0] = func3
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b01000;

  typedef enum logic [1:0] {
    PCS_SEQ  = 2'b00,
    PCS_BR   = 2'b01,
    PCS_JAL  = 2'b10,
    PCS_JALR = 2'b11
  } pcs_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_KILL = 1'b1
  } state_e;

  typedef struct packed {
    logic       illegal;
    logic       rwe;
    logic       mwe;
    logic [2:0] ramop;
    logic [4:0] aluop;
    logic       isimm;
    logic       is20;
    logic       isfpc;
    logic       isfm;
    logic       ispc4;
    pcs_e       pcs;   // PCS_BR means "conditional", resolved with ex_c in EX
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } ctrl_t;

  function automatic logic [2:0] load_ramop(input logic [2:0] f3);
    case (f3)
      3'b000:  return RAM_LB;
      3'b001:  return RAM_LH;
      3'b010:  return RAM_LW;
      3'b100:  return RAM_LBU;
      default: return RAM_LHU;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational RV32I(+M) decoder: instruction word -> control word.
//   instr_i     32-bit instruction in IF/ID
//   ctrl_o      decoded control word (illegal ops have rwe/mwe/pcs cleared)
//   rs1_used_o  instruction reads rs1
//   rs2_used_o  instruction reads rs2 (R/S/B types only)
module cu_decode
  import cu_pkg::*;
#(
  parameter int HAS_M = 1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        rs1_used_o,
  output logic        rs2_used_o
);

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       ill;

  assign op = instr_i[6:0];
  assign f3 = instr_i[14:12];
  assign f7 = instr_i[31:25];

  always_comb begin
    ctrl_o     = '0;
    ctrl_o.rd  = instr_i[11:7];
    ctrl_o.rs1 = instr_i[19:15];
    ctrl_o.rs2 = instr_i[24:20];
    rs1_used_o = 1'b0;
    rs2_used_o = 1'b0;
    ill        = 1'b0;
    case (op)
      OP_R: begin
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
        ctrl_o.rwe = 1'b1;
        if (f7 == 7'b0000001) begin
          if (HAS_M != 0) ctrl_o.aluop = {2'b10, f3};
          else            ill = 1'b1;
        end else if (f7 == 7'b0000000) begin
          ctrl_o.aluop = {2'b00, f3};
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          ctrl_o.aluop = {2'b01, f3};
        end else begin
          ill = 1'b1;
        end
      end
      OP_I: begin
        rs1_used_o   = 1'b1;
        ctrl_o.rwe   = 1'b1;
        ctrl_o.isimm = 1'b1;
        ctrl_o.aluop = {2'b00, f3};
        // shift-immediates carry func7 in the upper immediate bits
        if (f3 == 3'b001 && f7 != 7'b0000000) ill = 1'b1;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      ctrl_o.aluop = {2'b01, f3};
          else if (f7 != 7'b0000000) ill = 1'b1;
        end
      end
      OP_LOAD: begin
        rs1_used_o   = 1'b1;
        ctrl_o.rwe   = 1'b1;
        ctrl_o.isimm = 1'b1;
        ctrl_o.isfm  = 1'b1;
        ctrl_o.ramop = load_ramop(f3);
        if (f3 == 3'b011 || f3[2:1] == 2'b11) ill = 1'b1;
      end
      OP_STORE: begin
        rs1_used_o   = 1'b1;
        rs2_used_o   = 1'b1;
        ctrl_o.mwe   = 1'b1;
        ctrl_o.isimm = 1'b1;
        ctrl_o.isfm  = 1'b1;
        case (f3)
          3'b000:  ctrl_o.ramop = RAM_SB;
          3'b001:  ctrl_o.ramop = RAM_SH;
          3'b010:  ctrl_o.ramop = RAM_SW;
          default: ill = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        rs1_used_o = 1'b1;
        rs2_used_o = 1'b1;
        ctrl_o.pcs = PCS_BR;
        case (f3)
          3'b000, 3'b001: ctrl_o.aluop = ALU_SUB;
          3'b100, 3'b101: ctrl_o.aluop = ALU_SLT;
          3'b110, 3'b111: ctrl_o.aluop = ALU_SLTU;
          default:        ill = 1'b1;
        endcase
      end
      OP_JAL: begin
        ctrl_o.rwe   = 1'b1;
        ctrl_o.is20  = 1'b1;
        ctrl_o.ispc4 = 1'b1;
        ctrl_o.pcs   = PCS_JAL;
      end
      OP_JALR: begin
        rs1_used_o   = 1'b1;
        ctrl_o.rwe   = 1'b1;
        ctrl_o.isimm = 1'b1;
        ctrl_o.ispc4 = 1'b1;
        ctrl_o.pcs   = PCS_JALR;
        if (f3 != 3'b000) ill = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.rwe   = 1'b1;
        ctrl_o.isimm = 1'b1;
        ctrl_o.is20  = 1'b1;
      end
      OP_AUIPC: begin
        ctrl_o.rwe   = 1'b1;
        ctrl_o.isimm = 1'b1;
        ctrl_o.is20  = 1'b1;
        ctrl_o.isfpc = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // an illegal op still occupies an EX slot but must have no side effects
    if (ill) begin
      ctrl_o.rwe = 1'b0;
      ctrl_o.mwe = 1'b0;
      ctrl_o.pcs = PCS_SEQ;
      rs1_used_o = 1'b0;
      rs2_used_o = 1'b0;
    end
    if (ctrl_o.rd == 5'd0) ctrl_o.rwe = 1'b0;
    ctrl_o.illegal = ill;
  end

endmodule

// File: rtl/cu_pipe.sv
// Pipelined control unit: decodes IF/ID, registers the control word into ID/EX.
//   clk, rst_n        clock, asynchronous active-low reset
//   id_valid/id_ready IF/ID handshake (ready = taken or dropped this cycle)
//   id_instr          instruction word
//   ex_c              EX branch condition
//   mdu_busy          multi-cycle M unit busy, freezes EX
//   ex_*              ID/EX control word outputs, ex_pcs resolved with ex_c
//   redirect          PC must load target this cycle
module cu_pipe
  import cu_pkg::*;
#(
  parameter int HAS_M        = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int REG_AW       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [31:0]       id_instr,
  input  logic              ex_c,
  input  logic              mdu_busy,
  output logic              ex_valid,
  output logic [1:0]        ex_pcs,
  output logic              ex_rwe,
  output logic              ex_mwe,
  output logic [2:0]        ex_ramop,
  output logic [3+HAS_M:0]  ex_aluop,
  output logic              ex_isimm,
  output logic              ex_is20,
  output logic              ex_isfpc,
  output logic              ex_isfm,
  output logic              ex_ispc4,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic              ex_illegal,
  output logic              redirect
);

  localparam logic [1:0] KILL_INIT = 2'(FLUSH_CYCLES);

  ctrl_t      dec;
  logic       dec_rs1_used;
  logic       dec_rs2_used;
  ctrl_t      ex_q, ex_d;
  logic       ex_valid_q, ex_valid_d;
  state_e     state_q;
  logic [1:0] kill_cnt_q;
  logic [1:0] pcs_w;
  logic       hazard;

  cu_decode #(.HAS_M(HAS_M)) u_decode (
    .instr_i    (id_instr),
    .ctrl_o     (dec),
    .rs1_used_o (dec_rs1_used),
    .rs2_used_o (dec_rs2_used)
  );

  always_comb begin
    pcs_w = 2'b00;
    if (ex_valid_q) begin
      if (ex_q.pcs == PCS_BR) pcs_w = ex_c ? 2'b01 : 2'b00;
      else                    pcs_w = ex_q.pcs;
    end
  end

  assign redirect = ex_valid_q & (pcs_w != 2'b00);

  // load in EX whose destination is read by the instruction in ID
  assign hazard = ex_valid_q & ex_q.isfm & ex_q.rwe & (ex_q.rd != 5'd0) &
                  ((dec_rs1_used & (ex_q.rd == dec.rs1)) |
                   (dec_rs2_used & (ex_q.rd == dec.rs2)));

  always_comb begin
    id_ready   = 1'b0;
    ex_valid_d = ex_valid_q;
    ex_d       = ex_q;
    if (mdu_busy) begin
      // EX frozen, nothing accepted
    end else if (redirect || state_q == ST_KILL) begin
      id_ready   = id_valid;  // wrong-path instruction dropped
      ex_valid_d = 1'b0;
      ex_d       = '0;
    end else if (id_valid && hazard) begin
      ex_valid_d = 1'b0;
      ex_d       = '0;
    end else begin
      id_ready   = id_valid;
      ex_valid_d = id_valid;
      ex_d       = id_valid ? dec : '0;
    end
    if (!rst_n) id_ready = 1'b0;
  end

  // ID -> EX boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_q       <= ex_d;
    end
  end

  // Kill window: counts non-stalled cycles after the redirect cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      kill_cnt_q <= 2'd0;
    end else if (!mdu_busy) begin
      case (state_q)
        ST_RUN: begin
          if (redirect) begin
            state_q    <= ST_KILL;
            kill_cnt_q <= KILL_INIT;
          end
        end
        ST_KILL: begin
          if (kill_cnt_q <= 2'd1) begin
            state_q    <= ST_RUN;
            kill_cnt_q <= 2'd0;
          end else begin
            kill_cnt_q <= kill_cnt_q - 2'd1;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pcs     = pcs_w;
  assign ex_rwe     = ex_valid_q & ex_q.rwe;
  assign ex_mwe     = ex_valid_q & ex_q.mwe;
  assign ex_ramop   = ex_q.ramop;
  assign ex_aluop   = ex_q.aluop[3+HAS_M:0];
  assign ex_isimm   = ex_q.isimm;
  assign ex_is20    = ex_q.is20;
  assign ex_isfpc   = ex_q.isfpc;
  assign ex_isfm    = ex_q.isfm;
  assign ex_ispc4   = ex_q.ispc4;
  assign ex_rd      = ex_q.rd[REG_AW-1:0];
  assign ex_rs1     = ex_q.rs1[REG_AW-1:0];
  assign ex_rs2     = ex_q.rs2[REG_AW-1:0];
  assign ex_illegal = ex_valid_q & ex_q.illegal;

endmodule

// File: tb/tb_cu_pipe.sv
// Directed testbench for cu_pipe: one HAS_M=1 instance (main) and one
// HAS_M=0 instance driven by the same stimulus.
module tb_cu_pipe;

  localparam logic [31:0] I_LW   = 32'h0000A283; // lw   x5,0(x1)
  localparam logic [31:0] I_ADD  = 32'h00228333; // add  x6,x5,x2
  localparam logic [31:0] I_SW   = 32'h0020A223; // sw   x2,4(x1)
  localparam logic [31:0] I_BEQ  = 32'h00208463; // beq  x1,x2,8
  localparam logic [31:0] I_ADDI = 32'h00100393; // addi x7,x0,1
  localparam logic [31:0] I_JALR = 32'h000100E7; // jalr x1,0(x2)
  localparam logic [31:0] I_NOP0 = 32'h00000013; // addi x0,x0,0
  localparam logic [31:0] I_MUL  = 32'h022081B3; // mul  x3,x1,x2
  localparam logic [31:0] I_ZERO = 32'h00000000; // opcode 0000000

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic        ex_c = 1'b0;
  logic        mdu_busy = 1'b0;

  logic       id_ready, ex_valid, ex_rwe, ex_mwe, ex_isimm, ex_is20, ex_isfpc;
  logic       ex_isfm, ex_ispc4, ex_illegal, redirect;
  logic [1:0] ex_pcs;
  logic [2:0] ex_ramop;
  logic [4:0] ex_aluop, ex_rd, ex_rs1, ex_rs2;

  logic       n_id_ready, n_ex_valid, n_ex_rwe, n_ex_mwe, n_ex_isimm, n_ex_is20, n_ex_isfpc;
  logic       n_ex_isfm, n_ex_ispc4, n_ex_illegal, n_redirect;
  logic [1:0] n_ex_pcs;
  logic [2:0] n_ex_ramop;
  logic [3:0] n_ex_aluop;
  logic [4:0] n_ex_rd, n_ex_rs1, n_ex_rs2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cu_pipe #(.HAS_M(1), .FLUSH_CYCLES(1), .REG_AW(5)) u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .ex_c(ex_c), .mdu_busy(mdu_busy), .ex_valid(ex_valid),
    .ex_pcs(ex_pcs), .ex_rwe(ex_rwe), .ex_mwe(ex_mwe), .ex_ramop(ex_ramop),
    .ex_aluop(ex_aluop), .ex_isimm(ex_isimm), .ex_is20(ex_is20), .ex_isfpc(ex_isfpc),
    .ex_isfm(ex_isfm), .ex_ispc4(ex_ispc4), .ex_rd(ex_rd), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_illegal(ex_illegal), .redirect(redirect)
  );

  cu_pipe #(.HAS_M(0), .FLUSH_CYCLES(1), .REG_AW(5)) u_dut_nom (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(n_id_ready),
    .id_instr(id_instr), .ex_c(ex_c), .mdu_busy(mdu_busy), .ex_valid(n_ex_valid),
    .ex_pcs(n_ex_pcs), .ex_rwe(n_ex_rwe), .ex_mwe(n_ex_mwe), .ex_ramop(n_ex_ramop),
    .ex_aluop(n_ex_aluop), .ex_isimm(n_ex_isimm), .ex_is20(n_ex_is20), .ex_isfpc(n_ex_isfpc),
    .ex_isfm(n_ex_isfm), .ex_ispc4(n_ex_ispc4), .ex_rd(n_ex_rd), .ex_rs1(n_ex_rs1),
    .ex_rs2(n_ex_rs2), .ex_illegal(n_ex_illegal), .redirect(n_redirect)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr);
    id_valid = v;
    id_instr = instr;
    #1;
  endtask

  initial begin
    // reset state, with an instruction already presented
    drive(1'b1, I_LW);
    #10;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_ready", id_ready, 0);
    chk("rst_redirect", redirect, 0);
    chk("rst_ex_rwe", ex_rwe, 0);
    chk("rst_ex_pcs", ex_pcs, 0);
    rst_n = 1'b1;
    #1;

    // 1: load-use stall
    chk("lw_id_ready", id_ready, 1);
    tick();
    chk("lw_ex_valid", ex_valid, 1);
    chk("lw_ex_ramop", ex_ramop, 3'b010);
    chk("lw_ex_isfm", ex_isfm, 1);
    chk("lw_ex_rd", ex_rd, 5);
    drive(1'b1, I_ADD);
    chk("hz_id_ready", id_ready, 0);
    tick();
    chk("hz_bubble", ex_valid, 0);
    chk("hz_id_ready2", id_ready, 1);
    tick();
    chk("add_ex_valid", ex_valid, 1);
    chk("add_ex_rd", ex_rd, 6);
    chk("add_ex_rs1", ex_rs1, 5);
    chk("add_ex_rs2", ex_rs2, 2);
    chk("add_ex_aluop", ex_aluop, 0);
    chk("add_ex_rwe", ex_rwe, 1);

    // store
    drive(1'b1, I_SW);
    tick();
    chk("sw_ex_mwe", ex_mwe, 1);
    chk("sw_ex_rwe", ex_rwe, 0);
    chk("sw_ex_ramop", ex_ramop, 3'b111);

    // 2: branch not taken, then taken with kill window
    drive(1'b1, I_BEQ);
    tick();
    drive(1'b0, I_ADDI);
    chk("bnt_redirect", redirect, 0);
    chk("bnt_pcs", ex_pcs, 0);
    chk("beq_aluop", ex_aluop, 5'b01000);
    ex_c = 1'b1;
    drive(1'b1, I_ADDI);
    chk("bt_redirect", redirect, 1);
    chk("bt_pcs", ex_pcs, 2'b01);
    chk("bt_id_ready", id_ready, 1);
    tick();
    ex_c = 1'b0;
    #1;
    chk("bt_drop0", ex_valid, 0);
    chk("kill_id_ready", id_ready, 1);
    tick();
    chk("kill_drop1", ex_valid, 0);
    tick();
    chk("post_kill_valid", ex_valid, 1);
    chk("post_kill_rd", ex_rd, 7);
    chk("post_kill_isimm", ex_isimm, 1);

    // 3: jalr
    drive(1'b1, I_JALR);
    tick();
    drive(1'b0, I_ZERO);
    chk("jalr_pcs", ex_pcs, 2'b11);
    chk("jalr_ispc4", ex_ispc4, 1);
    chk("jalr_rwe", ex_rwe, 1);
    chk("jalr_isimm", ex_isimm, 1);
    chk("jalr_redirect", redirect, 1);
    tick();
    chk("jalr_bubble", ex_valid, 0);
    tick();

    // x0 destination
    drive(1'b1, I_NOP0);
    tick();
    chk("x0_valid", ex_valid, 1);
    chk("x0_rwe", ex_rwe, 0);

    // 4: M op held while the MDU is busy; 5: same op illegal without M
    drive(1'b1, I_MUL);
    tick();
    chk("mul_aluop", ex_aluop, 5'b10000);
    chk("mul_rwe", ex_rwe, 1);
    chk("mul_illegal", ex_illegal, 0);
    chk("nom_mul_illegal", n_ex_illegal, 1);
    chk("nom_mul_rwe", n_ex_rwe, 0);
    mdu_busy = 1'b1;
    drive(1'b1, I_ADDI);
    for (int i = 0; i < 4; i++) begin
      chk("busy_id_ready", id_ready, 0);
      tick();
      chk("busy_aluop", ex_aluop, 5'b10000);
      chk("busy_ex_rd", ex_rd, 3);
    end
    mdu_busy = 1'b0;
    #1;
    chk("unbusy_id_ready", id_ready, 1);
    tick();
    chk("unbusy_ex_rd", ex_rd, 7);

    drive(1'b1, I_ZERO);
    tick();
    chk("op0_illegal", ex_illegal, 1);
    chk("op0_valid", ex_valid, 1);
    chk("op0_rwe", ex_rwe, 0);
    chk("op0_pcs", ex_pcs, 0);
    chk("nom_op0_illegal", n_ex_illegal, 1);

    // 6: async reset during KILL, then normal issue
    drive(1'b1, I_BEQ);
    tick();
    drive(1'b0, I_ZERO);
    ex_c = 1'b1;
    tick();
    ex_c = 1'b0;
    drive(1'b1, I_ADDI);
    rst_n = 1'b0;
    #1;
    chk("rk_ex_valid", ex_valid, 0);
    chk("rk_redirect", redirect, 0);
    chk("rk_id_ready", id_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("rk_rel_id_ready", id_ready, 1);
    tick();
    chk("rk_issue_valid", ex_valid, 1);
    chk("rk_issue_rd", ex_rd, 7);

    // async reset clears a live EX word without a clock edge
    drive(1'b0, I_ZERO);
    rst_n = 1'b0;
    #1;
    chk("ar_ex_valid", ex_valid, 0);
    chk("ar_ex_rd", ex_rd, 0);
    chk("ar_ex_isimm", ex_isimm, 0);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
